// File: rtl/openddr_addr_encoder.sv
// openddr_addr_encoder: tracks open DDR banks/rows and rebuilds AXI byte addresses from RD/WR commands
module openddr_addr_encoder #(
    parameter int ADDR_WIDTH = 40,
    parameter int BANK_WIDTH = 3,
    parameter int ROW_WIDTH  = 16,
    parameter int COL_WIDTH  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_type,
    input  logic [BANK_WIDTH-1:0]         cmd_bank,
    input  logic [ROW_WIDTH-1:0]          cmd_row,
    input  logic [COL_WIDTH-1:0]          cmd_col,
    output logic                          addr_valid,
    input  logic                          addr_ready,
    output logic [ADDR_WIDTH-1:0]         addr_out,
    output logic                          addr_is_write,
    output logic [(1<<BANK_WIDTH)-1:0]    open_bank_mask,
    output logic                          err_closed_bank,
    output logic                          err_act_open,
    output logic [7:0]                    err_count
);
    localparam int NB = 1 << BANK_WIDTH;
    localparam logic [2:0] ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, PREA = 3'd5;
    logic                  acc, rw, hit, load, e_cb, e_ao;
    logic [NB-1:0]         open_q, open_d;
    logic [ROW_WIDTH-1:0]  row_q [NB];
    logic [ROW_WIDTH-1:0]  row_d [NB];
    logic                  valid_q, valid_d, wr_q, wr_d, err_cb_q, err_ao_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            cnt_q, cnt_d;
    assign cmd_ready = !valid_q || addr_ready;
    assign acc  = cmd_valid && cmd_ready;
    assign rw   = cmd_type == RD || cmd_type == WR;
    assign hit  = open_q[cmd_bank];
    assign load = acc && rw && hit;
    assign e_cb = acc && rw && !hit;
    assign e_ao = acc && cmd_type == ACT && hit;
    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        if (acc && cmd_type == ACT) begin
            open_d[cmd_bank] = 1'b1;
            row_d[cmd_bank]  = cmd_row;
        end else if (acc && cmd_type == PRE) begin
            open_d[cmd_bank] = 1'b0;
        end else if (acc && cmd_type == PREA) begin
            open_d = '0;
        end
        valid_d = load || (valid_q && !addr_ready);
        // row comes from the table as it stood before this command
        addr_d  = load ? ADDR_WIDTH'({row_q[cmd_bank], cmd_bank, cmd_col, 3'b000}) : addr_q;
        wr_d    = load ? cmd_type == WR : wr_q;
        cnt_d   = ((e_cb || e_ao) && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q   <= '0;
            for (int i = 0; i < NB; i++) row_q[i] <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            err_cb_q <= 1'b0;
            err_ao_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            open_q   <= open_d;
            row_q    <= row_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            err_cb_q <= e_cb;
            err_ao_q <= e_ao;
            cnt_q    <= cnt_d;
        end
    end
    assign addr_valid      = valid_q;
    assign addr_out        = addr_q;
    assign addr_is_write   = wr_q;
    assign open_bank_mask  = open_q;
    assign err_closed_bank = err_cb_q;
    assign err_act_open    = err_ao_q;
    assign err_count       = cnt_q;
endmodule

// File: tb/tb_openddr_addr_encoder.sv
// tb_openddr_addr_encoder: random and directed stimulus against a behavioural bank/address model
module tb_openddr_addr_encoder;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, addr_ready = 1'b1;
    logic [2:0]  cmd_type = '0;
    logic [2:0]  cmd_bank = '0;
    logic [15:0] cmd_row = '0;
    logic [9:0]  cmd_col = '0;
    logic        cmd_ready, addr_valid, addr_is_write, err_closed_bank, err_act_open;
    logic [39:0] addr_out;
    logic [7:0]  open_bank_mask, err_count;

    openddr_addr_encoder dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_out(addr_out),
        .addr_is_write(addr_is_write), .open_bank_mask(open_bank_mask),
        .err_closed_bank(err_closed_bank), .err_act_open(err_act_open), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    bit          m_open [8];
    int          m_row  [8];
    bit          m_valid, m_wr, m_ecb, m_eao;
    longint      m_addr;
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_open[i] = 0;
            m_row[i]  = 0;
        end
        m_valid = 0; m_wr = 0; m_ecb = 0; m_eao = 0; m_addr = 0; m_cnt = 0;
    endfunction

    function automatic logic [7:0] exp_mask();
        logic [7:0] m = '0;
        for (int i = 0; i < 8; i++) m[i] = m_open[i];
        return m;
    endfunction

    task automatic check_outputs();
        check("addr_valid", addr_valid, m_valid);
        if (m_valid) begin
            check("addr_out", addr_out, m_addr);
            check("addr_is_write", addr_is_write, m_wr);
        end
        check("open_bank_mask", open_bank_mask, exp_mask());
        check("err_closed_bank", err_closed_bank, m_ecb);
        check("err_act_open", err_act_open, m_eao);
        check("err_count", err_count, m_cnt);
    endtask

    // one clock cycle: called at a falling edge, returns at the next falling edge
    task automatic cycle(input bit v, input int t, input int b, input int r, input int c, input bit ar);
        bit acc, rw, hit;
        cmd_valid = v; cmd_type = 3'(t); cmd_bank = 3'(b); cmd_row = 16'(r); cmd_col = 10'(c);
        addr_ready = ar;
        #1;
        check("cmd_ready", cmd_ready, !m_valid || ar);
        acc = v && (!m_valid || ar);
        rw  = (t == 2 || t == 3);
        hit = m_open[b];
        m_ecb = acc && rw && !hit;
        m_eao = acc && t == 1 && hit;
        if (acc && rw && hit) begin
            m_valid = 1;
            m_addr  = ((longint'(m_row[b]) * 8 + b) * 1024 + c) * 8;
            m_wr    = (t == 3);
        end else if (m_valid && ar) m_valid = 0;
        if (acc && t == 1) begin
            m_open[b] = 1;
            m_row[b]  = r;
        end else if (acc && t == 4) m_open[b] = 0;
        else if (acc && t == 5) for (int i = 0; i < 8; i++) m_open[i] = 0;
        if ((m_ecb || m_eao) && m_cnt < 255) m_cnt++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        cycle(1, 1, 2, 'h1234, 0, 1);
        cycle(1, 2, 2, 0, 'h155, 1);
        check("rd_b2_addr", addr_out, 40'h0012344AA8);
        check("rd_b2_wr", addr_is_write, 1'b0);
        cycle(1, 1, 7, 'hFFFF, 0, 1);
        cycle(1, 3, 7, 0, 'h3FF, 1);
        check("wr_b7_addr", addr_out, 40'h00FFFFFFF8);
        check("wr_b7_wr", addr_is_write, 1'b1);
        idle();

        cycle(1, 2, 5, 0, 1, 1);
        check("rd_closed_pulse", err_closed_bank, 1'b1);
        idle();
        cycle(1, 5, 0, 0, 0, 1);
        cycle(1, 2, 2, 0, 1, 1);
        idle();
        check("err_count_two", err_count, 8'd2);
        cycle(1, 1, 2, 'h0AAA, 0, 1);
        cycle(1, 1, 2, 'h0BBB, 0, 1);
        check("act_open_pulse", err_act_open, 1'b1);
        cycle(1, 2, 2, 0, 0, 1);
        check("row_overwritten", addr_out, 40'h000BBB4000);

        cycle(1, 1, 1, 5, 0, 1);
        cycle(1, 2, 1, 0, 1, 0);
        cycle(1, 2, 1, 0, 2, 0);
        cycle(1, 2, 1, 0, 2, 0);
        check("held_first", addr_out, 40'h0000052008);
        cycle(1, 2, 1, 0, 2, 1);
        check("second_out", addr_out, 40'h0000052010);
        idle();

        repeat (3000) begin
            int t = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) t = 1;
            cycle(1'($urandom_range(0, 1)), t, $urandom_range(0, 7), $urandom_range(0, 65535),
                  $urandom_range(0, 1023), 1'($urandom_range(0, 3) != 0));
        end

        cycle(1, 5, 0, 0, 0, 1);
        cycle(1, 1, 0, 'h11, 0, 1);
        cycle(1, 1, 3, 'h33, 0, 1);
        cycle(1, 2, 0, 0, 4, 0);
        check("pre_reset_valid", addr_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", addr_valid, 1'b0);
        check("async_mask", open_bank_mask, 8'h00);
        check("async_addr", addr_out, 40'h0);
        check("async_cnt", err_count, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 2, 0, 0, 4, 1);
        check("post_reset_closed", err_closed_bank, 1'b1);
        repeat (300) cycle(1, 2, $urandom_range(0, 7), 0, 0, 1);
        check("err_saturate", err_count, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/openddr_addr_encoder.md
OPENDDR_ADDR_ENCODER -- requirements
Module: openddr_addr_encoder

Interface
REQ-001: The block SHALL have parameter ADDR_WIDTH, default 40, giving the reconstructed AXI address width.
REQ-002: The block SHALL have parameter BANK_WIDTH, default 3, giving the bank address width (8 banks).
REQ-003: The block SHALL have parameter ROW_WIDTH, default 16, giving the row address width.
REQ-004: The block SHALL have parameter COL_WIDTH, default 10, giving the column address width.
REQ-005: The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006: The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-007: The block SHALL have port cmd_valid, input, 1 bit: a DDR command is presented.
REQ-008: The block SHALL have port cmd_ready, output, 1 bit: the block accepts the command this cycle.
REQ-009: The block SHALL have port cmd_type, input, 3 bits, with encoding 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA; codes 6-7 are reserved.
REQ-010: The block SHALL have ports cmd_bank, cmd_row and cmd_col, inputs of BANK_WIDTH, ROW_WIDTH and COL_WIDTH bits respectively: the command address fields.
REQ-011: The block SHALL have port addr_valid, output, 1 bit: a reconstructed address is available.
REQ-012: The block SHALL have port addr_ready, input, 1 bit: the downstream consumer accepts the address.
REQ-013: The block SHALL have port addr_out, output, ADDR_WIDTH bits: the reconstructed byte address.
REQ-014: The block SHALL have port addr_is_write, output, 1 bit: 1 when addr_out came from WR, 0 when it came from RD.
REQ-015: The block SHALL have port open_bank_mask, output, 2**BANK_WIDTH bits: bit b is 1 while bank b is open.
REQ-016: The block SHALL have port err_closed_bank, output, 1 bit: a one-cycle pulse on an RD/WR to a closed bank.
REQ-017: The block SHALL have port err_act_open, output, 1 bit: a one-cycle pulse on an ACT to an already-open bank.
REQ-018: The block SHALL have port err_count, output, 8 bits: a saturating count of all error pulses.

Function
REQ-019: A command SHALL transfer only when cmd_valid && cmd_ready; cmd_ready = !addr_valid || addr_ready, with the same rule for all cmd_type values.
REQ-020: Per-bank state SHALL comprise a registered open bit and a registered ROW_WIDTH row; there are 2**BANK_WIDTH entries.
REQ-021: An accepted ACT SHALL set open[cmd_bank] and row[cmd_bank]=cmd_row; if the bank is already open, it SHALL also overwrite the row and pulse err_act_open.
REQ-022: An accepted PRE SHALL clear open[cmd_bank], and an accepted PREA SHALL clear all open bits; PRE to a closed bank SHALL raise no error.
REQ-023: An accepted RD/WR to an open bank SHALL load the output register on the next edge, giving 1-cycle latency.
REQ-024: The loaded value SHALL be addr_out = {zero-extend, row[cmd_bank], cmd_bank, cmd_col, 3'b000}, with column at bits [3 +: COL_WIDTH], bank at [3+COL_WIDTH +: BANK_WIDTH], row above the bank field, and remaining upper bits 0.
REQ-025: An accepted RD/WR to a closed bank SHALL be dropped, leaving addr_valid unchanged, and SHALL pulse err_closed_bank on the following cycle.
REQ-026: The row lookup SHALL use table state prior to the current command; a single command per cycle means no same-cycle table conflict arises.
REQ-027: NOP and reserved codes SHALL be accepted and ignored, raising no error.
REQ-028: addr_valid SHALL clear on addr_valid && addr_ready unless a new RD/WR loads in the same cycle, in which case it stays 1 with the new value (back-to-back throughput is 1 per cycle).
REQ-029: While addr_valid && !addr_ready, addr_out and addr_is_write SHALL hold stable and cmd_ready SHALL be 0.
REQ-030: err_count SHALL increment by 1 per error pulse and saturate at 0xFF; the two error types cannot pulse in the same cycle.
REQ-031: open_bank_mask SHALL reflect the registered open bits, updated on the edge after acceptance.

Reset
REQ-032: While rst_n=0, the block SHALL force addr_valid=0, addr_out=0, addr_is_write=0, open_bank_mask=0, all rows=0, err_closed_bank=0, err_act_open=0 and err_count=0, asynchronously.
REQ-033: A reset mid-transfer SHALL discard any pending address; after release, the first RD/WR without a prior ACT SHALL flag err_closed_bank.

Verification
REQ-034: ACT bank2 row 0x1234, then RD bank2 col 0x155 -> next cycle addr_valid=1, addr_out=0x0012344AA8, addr_is_write=0.
REQ-035: ACT bank7 row 0xFFFF, then WR bank7 col 0x3FF -> addr_out=0x00FFFFFFF8, addr_is_write=1.
REQ-036: RD bank5 with no ACT, and PREA followed by RD bank2 -> no addr_valid for either, err_closed_bank pulses 1 cycle each, err_count=2; ACT bank2 twice -> err_act_open pulse, row updated.
REQ-037: addr_ready=0 with two back-to-back RDs -> first address held stable, cmd_ready=0 holds the second; raising addr_ready delivers both in order, one per cycle.
REQ-038: rst_n asserted while addr_valid=1 and banks 0/3 open -> addr_valid=0 and open_bank_mask=0x00 immediately (no clock edge needed); 300 closed-bank RDs -> err_count=0xFF.
